// File: rtl/rr_mux_if.sv
// rr_mux_if: handshake bundle for the round-robin output-registered mux.
//   in_data   [NUM_IN*WIDTH] channel payloads, channel i at [i*WIDTH +: WIDTH]
//   in_valid  [NUM_IN]       per-channel valid
//   in_ready  [NUM_IN]       per-channel accept (one-hot or zero)
//   out_data  [WIDTH]        registered payload of the granted channel
//   out_sel   [SEL_W]        registered index of the channel behind out_data
//   out_valid                out_data/out_sel hold an unconsumed word
//   out_ready                downstream accept
// Modports: master = source/sink side (testbench), slave = rr_mux side.
interface rr_mux_if #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned NUM_IN = 4,
   parameter int unsigned SEL_W  = $clog2(NUM_IN)
);
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [NUM_IN-1:0]       in_valid;
   logic [NUM_IN-1:0]       in_ready;
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_sel;
   logic                    out_valid;
   logic                    out_ready;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_sel, out_valid
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_sel, out_valid
   );
endinterface

// File: rtl/rr_mux.sv
// rr_mux: NUM_IN-channel arbiter feeding a one-entry output register.
// Round-robin arbitration by default; defining RR_MUX_FIXED_PRIORITY_EN swaps in
// fixed priority (lowest valid index wins, no grant pointer kept).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rr_mux_if.slave (in_data/in_valid/in_ready, out_data/out_sel/out_valid/out_ready)
module rr_mux #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned NUM_IN = 4,
   parameter int unsigned SEL_W  = $clog2(NUM_IN)
) (
   input  logic        clk,
   input  logic        rst_n,
   rr_mux_if.slave     bus
);

   typedef enum logic [0:0] {StEmpty, StFull} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] data_q;
   logic [SEL_W-1:0] sel_q;
`ifndef RR_MUX_FIXED_PRIORITY_EN
   logic [SEL_W-1:0] last_q;
`endif

   logic             load_en;
   logic             grant;
   logic             grant_vld;
   logic [SEL_W-1:0] grant_idx;
   logic [SEL_W-1:0] idx;
   logic [WIDTH-1:0] grant_data;
   logic [NUM_IN-1:0] ready;
   logic [WIDTH-1:0] chan_data [NUM_IN];

   for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
      assign chan_data[g] = bus.in_data[g*WIDTH +: WIDTH];
   end

   // The output register can take a word when empty, or when the held word leaves this cycle.
   assign load_en = (state_q == StEmpty) || bus.out_ready;

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      idx       = '0;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
`ifdef RR_MUX_FIXED_PRIORITY_EN
         idx = SEL_W'(k);
`else
         // Search starts just after the last granted channel and wraps.
         idx = SEL_W'((32'(last_q) + k + 32'd1) % NUM_IN);
`endif
         if (!grant_vld && bus.in_valid[idx]) begin
            grant_vld = 1'b1;
            grant_idx = idx;
         end
      end
      grant_data = chan_data[grant_idx];
   end

   // Gated by rst_n so no channel sees an accept while reset is held.
   assign grant = rst_n && load_en && grant_vld;

   always_comb begin
      ready = '0;
      if (grant) begin
         ready[grant_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StEmpty;
         data_q  <= '0;
         sel_q   <= '0;
`ifndef RR_MUX_FIXED_PRIORITY_EN
         last_q  <= SEL_W'(NUM_IN - 1);
`endif
      end else if (load_en) begin
         if (grant) begin
            state_q <= StFull;
            data_q  <= grant_data;
            sel_q   <= grant_idx;
`ifndef RR_MUX_FIXED_PRIORITY_EN
            last_q  <= grant_idx;
`endif
         end else begin
            state_q <= StEmpty;
         end
      end
   end

   assign bus.in_ready  = ready;
   assign bus.out_data  = data_q;
   assign bus.out_sel   = sel_q;
   assign bus.out_valid = (state_q == StFull);

endmodule

// File: tb/tb_rr_mux.sv
// tb_rr_mux: self-checking bench for rr_mux (4 channels x 32 bits).
// Directed sequences with literal expectations, then randomized traffic checked every
// cycle against a behavioural model of the arbiter and output register.
// Honours RR_MUX_FIXED_PRIORITY_EN the same way the design does.
module tb_rr_mux;
   localparam int unsigned WIDTH  = 32;
   localparam int unsigned NUM_IN = 4;
   localparam int unsigned SEL_W  = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rr_mux_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) bus ();

   rr_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model, sampled on the falling edge ----------------
   bit               m_full = 1'b0;
   logic [WIDTH-1:0] m_data = '0;
   int               m_sel  = 0;
   int               m_last = NUM_IN - 1;
   int               m_wait [NUM_IN];
   logic [NUM_IN-1:0] exp_ready;
   bit               gv;
   int               gi;
   int               c;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_full = 1'b0;
         m_last = NUM_IN - 1;
         for (int i = 0; i < NUM_IN; i++) m_wait[i] = 0;
         chk("rst_in_ready", bus.in_ready, 0);
         chk("rst_out_valid", bus.out_valid, 0);
      end else begin
         gv = 1'b0;
         gi = 0;
         exp_ready = '0;
         if (!m_full || bus.out_ready) begin
            for (int k = 0; k < NUM_IN; k++) begin
`ifdef RR_MUX_FIXED_PRIORITY_EN
               c = k;
`else
               c = (m_last + 1 + k) % NUM_IN;
`endif
               if (!gv && bus.in_valid[c]) begin
                  gv = 1'b1;
                  gi = c;
               end
            end
         end
         if (gv) exp_ready[gi] = 1'b1;
         chk("in_ready", bus.in_ready, exp_ready);
         chk("out_valid", bus.out_valid, m_full);
         if (m_full) begin
            chk("out_data", bus.out_data, m_data);
            chk("out_sel", bus.out_sel, m_sel);
         end
`ifndef RR_MUX_FIXED_PRIORITY_EN
         // A continuously valid channel may see at most NUM_IN-1 other grants.
         for (int i = 0; i < NUM_IN; i++) begin
            if (!bus.in_valid[i] || (gv && i == gi)) m_wait[i] = 0;
            else if (gv) begin
               m_wait[i]++;
               chk("no_starve", (m_wait[i] <= NUM_IN - 1), 1);
            end
         end
`endif
         if (!m_full || bus.out_ready) begin
            if (gv) begin
               m_full = 1'b1;
               m_data = bus.in_data[gi*WIDTH +: WIDTH];
               m_sel  = gi;
               m_last = gi;
            end else begin
               m_full = 1'b0;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   int exp30 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
   int exp32 [4] = '{3, 0, 3, 0};

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      bus.in_valid  = '0;
      bus.out_ready = 1'b0;
      for (int i = 0; i < NUM_IN; i++) bus.in_data[i*WIDTH +: WIDTH] = $urandom;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      bus.in_valid = '1;
      #1;
      chk("reset_out_valid", bus.out_valid, 0);
      chk("reset_out_data", bus.out_data, 0);
      chk("reset_out_sel", bus.out_sel, 0);
      chk("reset_in_ready", bus.in_ready, 0);

      // Single word on channel 0.
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.in_valid = 4'b0001;
      bus.in_data[0 +: WIDTH] = 32'd3;
      bus.out_ready = 1'b1;
      #1;
      chk("r029_in_ready", bus.in_ready, 4'b0001);
      @(posedge clk); #1;
      bus.in_valid = '0;
      chk("r029_out_valid", bus.out_valid, 1);
      chk("r029_out_data", bus.out_data, 3);
      chk("r029_out_sel", bus.out_sel, 0);

      do_reset();
      bus.in_valid = 4'b1111;
      bus.out_ready = 1'b1;
      bus.in_data[3*WIDTH +: WIDTH] = 32'd15;
`ifdef RR_MUX_FIXED_PRIORITY_EN
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         chk("r034_out_valid", bus.out_valid, 1);
         chk("r034_out_sel", bus.out_sel, 0);
      end
`else
      // Rotation with all channels requesting.
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         chk("r030_out_valid", bus.out_valid, 1);
         chk("r030_out_sel", bus.out_sel, exp30[i]);
      end
      // Stall while full: nothing accepted, word held.
      chk("r031_out_data_initial", bus.out_data, 15);
      bus.out_ready = 1'b0;
      bus.in_valid = 4'b0110;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("r031_in_ready_stall", bus.in_ready, 0);
         @(posedge clk); #1;
         chk("r031_out_data_hold", bus.out_data, 15);
         chk("r031_out_sel_hold", bus.out_sel, 3);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("r031_in_ready_resume", bus.in_ready, 4'b0010);
      @(posedge clk); #1;
      chk("r031_out_sel_resume", bus.out_sel, 1);
      // Wrap-around between channels 3 and 0.
      bus.in_valid = 4'b1001;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("r032_out_sel", bus.out_sel, exp32[i]);
      end
      // Asynchronous reset while full.
      #1;
      rst_n = 1'b0;
      #1;
      chk("r033_out_valid_async", bus.out_valid, 0);
      chk("r033_out_sel_async", bus.out_sel, 0);
      chk("r033_out_data_async", bus.out_data, 0);
      chk("r033_in_ready_async", bus.in_ready, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.in_valid = 4'b1111;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("r033_first_valid", bus.out_valid, 1);
      chk("r033_first_sel", bus.out_sel, 0);
`endif

      // Randomized traffic with occasional reset pulses.
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk); #1;
         if ($urandom_range(0, 299) == 0) begin
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
         end
         if ($urandom_range(0, 1) == 0) bus.in_valid = NUM_IN'($urandom & $urandom);
         else bus.in_valid = NUM_IN'($urandom);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NUM_IN; i++) bus.in_data[i*WIDTH +: WIDTH] = $urandom;
      end
      @(posedge clk); #1;
      @(posedge clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
